signal_detector: RTL
====================

Name: signal_detector

Overview:
- Receiving end of the serial test-signal path: samples the 1-bit serial stream from a signal creater (one bit per clk) and searches for a fixed LEN-bit repeating pattern.
- Once the pattern is found, locks to its phase and checks every later bit against the expected pattern.
- Reports lock status, a per-period frame pulse and a saturating error count.
- Used as the on-chip checker that closes the loop around the pattern generators.

Parameters:
- LEN, 10, pattern period in bits (2..32).
- PATTERN, 10'b1101001110, expected period; PATTERN[LEN-1] is transmitted first.
- ERR_W, 8, width of err_cnt.
- LOSS, 3, consecutive mismatches that drop lock (1..7).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- in  input  1  serial data, one bit per clk, sampled every rising edge.
- locked  output  1  high while in LOCKED.
- frame  output  1  one-cycle pulse at each error-free completed period while locked, including the locking period.
- err_cnt  output  ERR_W  mismatches counted while locked; saturates at all-ones.
- phase  output  $clog2(LEN)  index of the next expected bit in LOCKED; 0 in SEARCH.

Behaviour:
- Reset: rst==0 at a rising edge clears state to SEARCH and sets sr=0, bits_seen=0, miss_run=0, locked=0, frame=0, err_cnt=0, phase=0. Reset overrides all other events and is honoured mid-lock or mid-search. Outputs are registered; there is no asynchronous path.
- Shift register sr[LEN-1:0] updates every non-reset edge: sr <= {sr[LEN-2:0], in}.
- bits_seen increments and saturates at LEN-1.
- window = {sr[LEN-2:0], in}. The window is valid when bits_seen == LEN-1.
- SEARCH, window valid and window==PATTERN:
  - Next state LOCKED, phase<=0, miss_run<=0, frame<=1, locked<=1.
  - locked therefore rises on the edge that samples the last pattern bit, and is visible the following cycle.
- SEARCH, otherwise: stay; frame<=0.
- LOCKED, every edge:
  - exp = PATTERN[LEN-1-phase].
  - phase <= (phase==LEN-1) ? 0 : phase+1.
  - per-period flag perr is set on mismatch and cleared on wrap.
- LOCKED, in != exp:
  - err_cnt <= err_cnt+1, held at 2^ERR_W-1.
  - miss_run <= miss_run+1; perr<=1.
- LOCKED, in == exp: miss_run<=0.
- LOCKED, phase==LEN-1 and the period had no mismatch, current bit included: frame<=1. Otherwise frame<=0.
- Loss of lock, when a mismatch makes miss_run reach LOSS:
  - Next state SEARCH, locked<=0, phase<=0, miss_run<=0, frame<=0.
  - bits_seen is kept, so re-acquisition can occur on any later valid window, at the earliest the next cycle.
  - err_cnt is retained; only rst clears it.
- Simultaneous events:
  - Loss and wrap on the same edge: loss wins and frame=0.
  - A mismatch on the wrap bit suppresses that period's frame.
- Mismatches fewer than LOSS in a row: remain LOCKED, no phase slip, count errors.

Test Plan:
- Reset: hold rst=0 for 2 cycles with random in -> locked=0, frame=0, err_cnt=0, phase=0.
- Acquisition: after reset, feed 3 bits of 0 then PATTERN MSB-first repeated -> locked rises 1 cycle after the 13th bit edge; frame pulses at that edge and every 10 cycles after; err_cnt stays 0.
- Single error: while locked, invert 1 bit at phase 4 -> err_cnt=1, frame missing for that period only, locked stays 1, next period frame returns.
- Loss: while locked, invert 3 consecutive bits -> err_cnt=3, locked falls after the 3rd; resume the correct stream -> re-lock within 10 cycles of a full aligned window.
- Saturation: ERR_W=2, force 2 errors per period over several periods -> err_cnt sticks at 3, no wrap to 0.
- Mid-lock reset: rst=0 for one edge while locked with err_cnt=5 -> next cycle locked=0, err_cnt=0, and 10 fresh pattern bits are needed before relock.

Source files
------------

// File: rtl/signal_detector.sv
// Serial pattern checker: hunts for a fixed LEN-bit period, locks to its phase,
// then flags per-period frames and counts bit errors until lock is lost.
module signal_detector #(
  parameter int unsigned          LEN     = 10,
  parameter logic [LEN-1:0]       PATTERN = 10'b1101001110,
  parameter int unsigned          ERR_W   = 8,
  parameter int unsigned          LOSS    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in,
  output logic                    locked,
  output logic                    frame,
  output logic [ERR_W-1:0]        err_cnt,
  output logic [$clog2(LEN)-1:0]  phase
);

  localparam int unsigned PH_W   = $clog2(LEN);
  localparam int unsigned MISS_W = 3;

  localparam logic [0:0] SEARCH = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]        state, state_nxt;
  // Only the LEN-1 most recent bits are kept; the incoming bit completes the window.
  logic [LEN-2:0]    sr, sr_nxt;
  logic [PH_W-1:0]   bits_seen, bits_seen_nxt;
  logic [MISS_W-1:0] miss_run, miss_nxt;
  logic              perr, perr_nxt;
  logic              locked_nxt;
  logic              frame_nxt;
  logic [ERR_W-1:0]  err_nxt;
  logic [PH_W-1:0]   phase_nxt;

  logic [LEN-1:0]    window_c;
  logic              win_valid_c;
  logic              exp_bit_c;
  logic              mismatch_c;
  logic              wrap_c;
  logic [MISS_W-1:0] miss_inc_c;

  assign window_c    = {sr, in};
  assign win_valid_c = (bits_seen == PH_W'(LEN - 1));
  assign exp_bit_c   = PATTERN[PH_W'(LEN - 1) - phase];
  assign mismatch_c  = (in != exp_bit_c);
  assign wrap_c      = (phase == PH_W'(LEN - 1));
  assign miss_inc_c  = miss_run + MISS_W'(1);

  // Next-state and registered-output decode
  always_comb begin
    state_nxt     = state;
    sr_nxt        = window_c[LEN-2:0];
    bits_seen_nxt = win_valid_c ? bits_seen : bits_seen + PH_W'(1);
    miss_nxt      = miss_run;
    perr_nxt      = perr;
    locked_nxt    = locked;
    frame_nxt     = 1'b0;
    err_nxt       = err_cnt;
    phase_nxt     = phase;

    case (state)
      SEARCH: begin
        if (win_valid_c && (window_c == PATTERN)) begin
          state_nxt  = LOCKED;
          phase_nxt  = '0;
          miss_nxt   = '0;
          perr_nxt   = 1'b0;
          frame_nxt  = 1'b1;
          locked_nxt = 1'b1;
        end
      end
      LOCKED: begin
        phase_nxt = wrap_c ? '0 : phase + PH_W'(1);
        perr_nxt  = wrap_c ? 1'b0 : (perr | mismatch_c);
        frame_nxt = wrap_c & ~mismatch_c & ~perr;
        if (mismatch_c) begin
          err_nxt  = (&err_cnt) ? err_cnt : err_cnt + ERR_W'(1);
          miss_nxt = miss_inc_c;
          // Loss takes priority over a simultaneous wrap
          if (miss_inc_c == MISS_W'(LOSS)) begin
            state_nxt  = SEARCH;
            locked_nxt = 1'b0;
            phase_nxt  = '0;
            miss_nxt   = '0;
            perr_nxt   = 1'b0;
            frame_nxt  = 1'b0;
          end
        end else begin
          miss_nxt = '0;
        end
      end
      default: begin
        state_nxt  = SEARCH;
        locked_nxt = 1'b0;
        phase_nxt  = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= SEARCH;
      sr        <= '0;
      bits_seen <= '0;
      miss_run  <= '0;
      perr      <= 1'b0;
      locked    <= 1'b0;
      frame     <= 1'b0;
      err_cnt   <= '0;
      phase     <= '0;
    end else begin
      state     <= state_nxt;
      sr        <= sr_nxt;
      bits_seen <= bits_seen_nxt;
      miss_run  <= miss_nxt;
      perr      <= perr_nxt;
      locked    <= locked_nxt;
      frame     <= frame_nxt;
      err_cnt   <= err_nxt;
      phase     <= phase_nxt;
    end
  end

endmodule
